// File: rtl/set_bit_iterator.sv
// Walks the set bits of a captured vector, MSB first, one index per handshake.
// Ports: vec in (valid/ready), lod_vec/lod_index to an external detector,
//        idx out (valid/ready, last), remaining count, zero pulse, sticky err.
module set_bit_iterator #(
  parameter int DATA_WD = 8,
  parameter int IND_WD  = $clog2(DATA_WD)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_vec_valid,
  output logic               o_vec_ready,
  input  logic [DATA_WD-1:0] i_vec,
  output logic [DATA_WD-1:0] o_lod_vec,
  input  logic [IND_WD-1:0]  i_lod_index,
  output logic               o_idx_valid,
  input  logic               i_idx_ready,
  output logic [IND_WD-1:0]  o_idx,
  output logic               o_idx_last,
  output logic [IND_WD:0]    o_remaining,
  output logic               o_zero_pulse,
  output logic               o_err
);

  typedef enum logic {
    IDLE,
    ITER
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DATA_WD-1:0] rem_q;
  logic [DATA_WD-1:0] rem_d;
  logic [DATA_WD-1:0] hit_mask;
  logic [DATA_WD-1:0] rem_clr;
  logic               hit;
  logic               clr_empty;
  logic               err_d;
  logic               zero_d;

  // One-hot decode of the detector index; an out-of-range
  // index simply decodes to no bit.
  always_comb begin
    hit_mask = '0;
    for (int i = 0; i < DATA_WD; i++) begin
      hit_mask[i] = (IND_WD'(i) == i_lod_index);
    end
  end

  assign hit       = |(rem_q & hit_mask);
  assign rem_clr   = rem_q & ~hit_mask;
  assign clr_empty = ~|rem_clr;

  assign o_lod_vec = rem_q;
  assign o_idx     = i_lod_index;

  always_comb begin
    o_remaining = '0;
    for (int i = 0; i < DATA_WD; i++) begin
      o_remaining = o_remaining
                  + (IND_WD+1)'(rem_q[i]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      o_err        <= 1'b0;
      o_zero_pulse <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      o_err        <= err_d;
      o_zero_pulse <= zero_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    err_d       = o_err;
    zero_d      = 1'b0;
    o_vec_ready = 1'b0;
    o_idx_valid = 1'b0;
    o_idx_last  = 1'b0;
    unique case (state_q)
      IDLE: begin
        o_vec_ready = 1'b1;
        rem_d       = '0;
        if (i_vec_valid) begin
          if (|i_vec) begin
            rem_d   = i_vec;
            state_d = ITER;
          end else begin
            zero_d  = 1'b1;
          end
        end
      end
      ITER: begin
        o_idx_valid = 1'b1;
        o_idx_last  = clr_empty;
        if (!hit) begin
          err_d = 1'b1;
        end
        if (i_idx_ready) begin
          rem_d = rem_clr;
          // A bogus index would leave rem_q unchanged;
          // bail out to IDLE instead of spinning.
          if (clr_empty || !hit) begin
            rem_d   = '0;
            state_d = IDLE;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_set_bit_iterator.sv
// Testbench for set_bit_iterator: directed and random vectors
// checked against a bit-list reference model.
module tb_set_bit_iterator;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_vec_valid;
  logic       o_vec_ready;
  logic [7:0] i_vec;
  logic [7:0] o_lod_vec;
  logic [2:0] i_lod_index;
  logic       o_idx_valid;
  logic       i_idx_ready;
  logic [2:0] o_idx;
  logic       o_idx_last;
  logic [3:0] o_remaining;
  logic       o_zero_pulse;
  logic       o_err;

  logic       force_en;
  logic [2:0] force_val;

  int tests;
  int failed;

  set_bit_iterator #(.DATA_WD(8), .IND_WD(3)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_vec_valid  (i_vec_valid),
    .o_vec_ready  (o_vec_ready),
    .i_vec        (i_vec),
    .o_lod_vec    (o_lod_vec),
    .i_lod_index  (i_lod_index),
    .o_idx_valid  (o_idx_valid),
    .i_idx_ready  (i_idx_ready),
    .o_idx        (o_idx),
    .o_idx_last   (o_idx_last),
    .o_remaining  (o_remaining),
    .o_zero_pulse (o_zero_pulse),
    .o_err        (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // External leading-one detector, optionally overridden.
  always_comb begin
    i_lod_index = '0;
    for (int i = 0; i < 8; i++) begin
      if (o_lod_vec[i]) i_lod_index = 3'(i);
    end
    if (force_en) i_lod_index = force_val;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // mode 0: ready always high, 1: toggling 1,0,..., 2: random
  task automatic run_vec(input logic [7:0] v, input int mode);
    int         q[$];
    logic [7:0] exp_rem;
    int         cyc;
    bit         rdy;
    for (int b = 7; b >= 0; b--) begin
      if (v[b]) q.push_back(b);
    end
    exp_rem = v;
    chk("vec_ready_idle", 32'(o_vec_ready), 1);
    i_vec_valid = 1'b1;
    i_vec       = v;
    step();
    i_vec_valid = 1'b0;
    i_vec       = 8'($urandom);
    if (q.size() == 0) begin
      chk("zero_pulse_hi", 32'(o_zero_pulse), 1);
      chk("zero_no_valid", 32'(o_idx_valid), 0);
      chk("zero_vec_ready", 32'(o_vec_ready), 1);
      step();
      chk("zero_pulse_lo", 32'(o_zero_pulse), 0);
      return;
    end
    chk("no_zero_pulse", 32'(o_zero_pulse), 0);
    cyc = 0;
    while (q.size() > 0 && cyc < 64) begin
      chk("idx_valid", 32'(o_idx_valid), 1);
      chk("vec_ready_busy", 32'(o_vec_ready), 0);
      chk("idx", 32'(o_idx), 32'(q[0]));
      chk("idx_last", 32'(o_idx_last), 32'(q.size() == 1));
      chk("remaining", 32'(o_remaining), 32'(q.size()));
      chk("lod_vec", 32'(o_lod_vec), 32'(exp_rem));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom);
      endcase
      i_idx_ready = rdy;
      step();
      cyc++;
      if (rdy) begin
        exp_rem[q[0]] = 1'b0;
        void'(q.pop_front());
      end
    end
    i_idx_ready = 1'b0;
    chk("iter_timeout", 32'(q.size()), 0);
    chk("end_vec_ready", 32'(o_vec_ready), 1);
    chk("end_idx_valid", 32'(o_idx_valid), 0);
    chk("end_lod_vec", 32'(o_lod_vec), 0);
  endtask

  initial begin
    tests       = 0;
    failed      = 0;
    force_en    = 1'b0;
    force_val   = '0;
    i_rst_n     = 1'b0;
    i_vec_valid = 1'b0;
    i_vec       = '0;
    i_idx_ready = 1'b0;
    #2;
    chk("rst_vec_ready", 32'(o_vec_ready), 1);
    chk("rst_lod_vec", 32'(o_lod_vec), 0);
    chk("rst_idx_valid", 32'(o_idx_valid), 0);
    chk("rst_idx_last", 32'(o_idx_last), 0);
    chk("rst_idx_pass", 32'(o_idx), 32'(i_lod_index));
    chk("rst_remaining", 32'(o_remaining), 0);
    chk("rst_zero", 32'(o_zero_pulse), 0);
    chk("rst_err", 32'(o_err), 0);
    step();
    i_rst_n = 1'b1;
    step();

    run_vec(8'hA4, 0);
    run_vec(8'hFF, 1);
    run_vec(8'h00, 0);

    // Back-to-back offer: 01 then 80 with valid held high.
    i_vec_valid = 1'b1;
    i_vec       = 8'h01;
    i_idx_ready = 1'b1;
    step();
    i_vec = 8'h80;
    chk("b2b_idx0", 32'(o_idx), 0);
    chk("b2b_last0", 32'(o_idx_last), 1);
    chk("b2b_busy", 32'(o_vec_ready), 0);
    step();
    chk("b2b_idle_gap", 32'(o_idx_valid), 0);
    chk("b2b_idle_rdy", 32'(o_vec_ready), 1);
    step();
    i_vec_valid = 1'b0;
    chk("b2b_idx7", 32'(o_idx), 7);
    chk("b2b_last7", 32'(o_idx_last), 1);
    chk("b2b_lod", 32'(o_lod_vec), 32'h80);
    step();
    i_idx_ready = 1'b0;
    chk("b2b_done", 32'(o_vec_ready), 1);

    // Reset mid-iteration discards the vector.
    i_vec_valid = 1'b1;
    i_vec       = 8'hF0;
    i_idx_ready = 1'b1;
    step();
    i_vec_valid = 1'b0;
    chk("mid_idx7", 32'(o_idx), 7);
    step();
    chk("mid_idx6", 32'(o_idx), 6);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(o_idx_valid), 0);
    chk("mid_rst_lod", 32'(o_lod_vec), 0);
    chk("mid_rst_rem", 32'(o_remaining), 0);
    step();
    i_rst_n = 1'b1;
    step();
    chk("post_rst_ready", 32'(o_vec_ready), 1);
    chk("post_rst_valid", 32'(o_idx_valid), 0);
    step();
    chk("post_rst_stale", 32'(o_idx_valid), 0);
    i_idx_ready = 1'b0;

    // Bogus detector index raises sticky err, no hang.
    i_vec_valid = 1'b1;
    i_vec       = 8'h80;
    step();
    i_vec_valid = 1'b0;
    force_en    = 1'b1;
    force_val   = 3'd3;
    #1;
    chk("err_pre", 32'(o_err), 0);
    step();
    chk("err_set", 32'(o_err), 1);
    chk("err_hold_valid", 32'(o_idx_valid), 1);
    i_idx_ready = 1'b1;
    step();
    i_idx_ready = 1'b0;
    force_en    = 1'b0;
    chk("err_to_idle", 32'(o_vec_ready), 1);
    chk("err_no_valid", 32'(o_idx_valid), 0);
    chk("err_lod_clr", 32'(o_lod_vec), 0);
    chk("err_sticky", 32'(o_err), 1);
    run_vec(8'h5A, 0);
    chk("err_sticky2", 32'(o_err), 1);
    i_rst_n = 1'b0;
    #1;
    chk("err_rst", 32'(o_err), 0);
    step();
    i_rst_n = 1'b1;
    step();

    for (int n = 0; n < 40; n++) begin
      run_vec(8'($urandom), 2);
    end
    chk("rand_no_err", 32'(o_err), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/set_bit_iterator.md
# set_bit_iterator

Walks the set bits of a captured DATA_WD-bit vector from most significant to least significant and emits one bit index per handshake. It sits directly around a combinational leading-one detector. Each cycle it drives the remaining vector to the detector, consumes the detector's index, and streams that index downstream. After each accepted index it clears the corresponding bit, until the vector is empty.

## Interface
- DATA_WD, 8, width of the input vector (≥2)
- IND_WD, $clog2(DATA_WD), width of a bit index
- i_clk  input  1  single clock; all state updates on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_vec_valid  input  1  upstream vector valid
- o_vec_ready  output  1  block can accept a vector (high only in IDLE)
- i_vec  input  DATA_WD  vector to iterate
- o_lod_vec  output  DATA_WD  remaining vector, driven to external leading-one detector
- i_lod_index  input  IND_WD  detector result for o_lod_vec (combinational, same cycle)
- o_idx_valid  output  1  index valid
- i_idx_ready  input  1  downstream accepts index
- o_idx  output  IND_WD  current bit index (highest remaining set bit)
- o_idx_last  output  1  o_idx is the final set bit of the vector
- o_remaining  output  IND_WD+1  popcount of the remaining vector
- o_zero_pulse  output  1  one-cycle pulse: an all-zero vector was accepted
- o_err  output  1  sticky: detector returned an index whose bit is not set

## Operation
- Register rem_q[DATA_WD]; state machine with states IDLE and ITER.
- IDLE: o_vec_ready=1, o_idx_valid=0, rem_q=0.
  - On i_vec_valid && o_vec_ready with i_vec != 0: rem_q <= i_vec, go to ITER.
  - On i_vec_valid && o_vec_ready with i_vec == 0: stay in IDLE, o_zero_pulse=1 on the next cycle, emit no index.
- ITER: o_vec_ready=0, o_idx_valid=1.
  - o_idx = i_lod_index.
  - o_idx_last = ((rem_q with bit i_lod_index cleared) == 0).
- ITER, on o_idx_valid && i_idx_ready:
  - rem_q[i_lod_index] <= 0.
  - If o_idx_last, go to IDLE.
- ITER without a handshake: rem_q, o_idx and o_idx_last hold stable. The valid-hold rule applies: o_idx_valid never drops while in ITER.
- o_lod_vec = rem_q at all times, so it is 0 in IDLE.
- o_remaining = popcount(rem_q), a combinational function of the register.
- o_err:
  - Set when in ITER and rem_q[i_lod_index]==0.
  - Cleared only by reset.
  - Does not alter iteration. If the clearing update would leave rem_q unchanged, the block still advances by forcing state to IDLE, so it cannot hang.
- Reset (asynchronous, any time, including mid-iteration): state=IDLE, rem_q=0, o_err=0, o_zero_pulse=0.
  - A partially iterated vector is discarded with no further indices.
- No new vector is accepted until the final index handshakes. The IDLE cycle between vectors is mandatory.

## Timing
- Reset values:
  - o_vec_ready=1
  - o_lod_vec=0
  - o_idx_valid=0
  - o_idx = i_lod_index passthrough
  - o_idx_last=0 (forced 0 in IDLE)
  - o_remaining=0
  - o_zero_pulse=0
  - o_err=0
- Accept at edge N: o_idx_valid high from cycle N+1 with the first index.
- Throughput with i_idx_ready held high: one index per cycle. A vector with k set bits occupies k ITER cycles plus 1 IDLE cycle.
- o_vec_ready goes high the cycle after the last index handshake.
- o_zero_pulse is high for exactly the one cycle after the accepting edge.
- The path i_lod_index -> o_idx / o_idx_last is combinational. The path o_lod_vec -> i_lod_index is external. Together they form one combinational loop-free path per cycle.

## Test plan
- Vector 8'hA4, ready always high -> o_idx = 7, 5, 2 on consecutive cycles; o_idx_last=1 only with 2; o_remaining 3, 2, 1; o_vec_ready high on the following cycle.
- Vector 8'hFF with i_idx_ready toggling 1,0,1,0… -> indices 7 down to 0 in order, each held stable while ready=0; 8 handshakes total; o_idx_last only on index 0.
- Vector 8'h00 -> accepted in IDLE; o_zero_pulse high for one cycle; o_idx_valid stays 0; o_vec_ready stays 1.
- Vector 8'h01, then 8'h80 offered back-to-back -> index 0 (last) emitted; second vector accepted only after the mandatory IDLE cycle; then index 7 (last).
- Vector 8'hF0, assert i_rst_n=0 after the first handshake (index 7) -> immediately o_idx_valid=0, o_lod_vec=0, o_remaining=0; after release, o_vec_ready=1 and no stale indices are emitted.
- Bench detector model forced to return 3 while rem_q=8'h80 -> o_err=1 and stays 1 until reset; no hang: block returns to IDLE after the handshake.
